mef_pattern_det: RTL and testbench

//  Parametrised successor of the single-pattern serial FSM detector: watches a serial bit stream E
//  and pulses Y for one cycle whenever the last PAT_W accepted bits match a runtime-loadable,

---
 rtl/mef_pattern_det.sv | 117 +++++++++++
 tb/tb_mef_pattern_det.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/mef_pattern_det.sv
`default_nettype none
// ============================================================================
//  Module   : mef_pattern_det
//  Purpose  : Serial pattern detector with a loadable, maskable pattern,
//             selectable overlap mode and a saturating hit counter.
//  Revision : 1.0 - initial release
// ============================================================================
module mef_pattern_det #(
    parameter int               PAT_W       = 4,
    parameter logic [PAT_W-1:0] PAT_DEFAULT = 4'b1011,
    parameter int               CNT_W       = 8
) (
    input  logic             clk_i,
    input  logic             clr_n_i,
    input  logic             en_i,
    input  logic             e_i,
    input  logic             mode_ovl_i,
    input  logic             pat_ld_i,
    input  logic [PAT_W-1:0] pat_in_i,
    input  logic [PAT_W-1:0] mask_in_i,
    input  logic             cnt_clr_i,
    output logic             y_o,
    output logic [CNT_W-1:0] hits_o,
    output logic             armed_o
);

    localparam int             FW        = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_W);
    localparam logic [CNT_W-1:0] HITS_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        ARMED   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] hist_q, hist_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [PAT_W-1:0] mask_q, mask_d;
    logic             y_q, y_d;
    logic [CNT_W-1:0] hits_q, hits_d;

    logic             accept;
    logic [PAT_W-1:0] hist_shift;
    logic [FW-1:0]    fill_inc;
    logic             hit;

    // A load cycle swallows E, so only non-load enabled cycles shift history.
    assign accept     = en_i & ~pat_ld_i;
    assign hist_shift = {hist_q[PAT_W-2:0], e_i};
    assign fill_inc   = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + FW'(1);
    assign hit        = accept && (fill_inc == FILL_FULL) &&
                        (((hist_shift ^ pat_q) & mask_q) == '0);

    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        pat_d   = pat_q;
        mask_d  = mask_q;
        y_d     = hit;
        hits_d  = hits_q;

        if (pat_ld_i) begin
            pat_d   = pat_in_i;
            mask_d  = mask_in_i;
            hist_d  = '0;
            fill_d  = '0;
            state_d = EMPTY;
        end else if (accept) begin
            if (hit && !mode_ovl_i) begin
                // Non-overlapping: the matching bit is consumed, refill from scratch.
                hist_d  = '0;
                fill_d  = '0;
                state_d = EMPTY;
            end else begin
                hist_d  = hist_shift;
                fill_d  = fill_inc;
                state_d = (fill_inc == FILL_FULL) ? ARMED : FILLING;
            end
        end

        if (cnt_clr_i) begin
            hits_d = '0;
        end else if (hit && (hits_q != HITS_MAX)) begin
            hits_d = hits_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            state_q <= EMPTY;
            hist_q  <= '0;
            fill_q  <= '0;
            pat_q   <= PAT_DEFAULT;
            mask_q  <= '1;
            y_q     <= 1'b0;
            hits_q  <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            y_q     <= y_d;
            hits_q  <= hits_d;
        end
    end

    assign y_o     = y_q;
    assign hits_o  = hits_q;
    assign armed_o = (state_q == ARMED);

endmodule
`default_nettype wire

// File: tb/tb_mef_pattern_det.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mef_pattern_det
//  Purpose  : Directed self-checking bench for mef_pattern_det (PAT_W=4, CNT_W=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mef_pattern_det;

    localparam int PAT_W = 4;
    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             clr_n = 1'b0;
    logic             en = 1'b0;
    logic             e = 1'b0;
    logic             ovl = 1'b1;
    logic             pat_ld = 1'b0;
    logic [PAT_W-1:0] pat_in = '0;
    logic [PAT_W-1:0] mask_in = '0;
    logic             cnt_clr = 1'b0;
    logic             y;
    logic [CNT_W-1:0] hits;
    logic             armed;

    int checks = 0;
    int failures = 0;

    mef_pattern_det #(
        .PAT_W      (PAT_W),
        .PAT_DEFAULT(4'b1011),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i      (clk),
        .clr_n_i    (clr_n),
        .en_i       (en),
        .e_i        (e),
        .mode_ovl_i (ovl),
        .pat_ld_i   (pat_ld),
        .pat_in_i   (pat_in),
        .mask_in_i  (mask_in),
        .cnt_clr_i  (cnt_clr),
        .y_o        (y),
        .hits_o     (hits),
        .armed_o    (armed)
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic bit_in(input logic b);
        e  = b;
        en = 1'b1;
        cyc();
        en = 1'b0;
    endtask

    // Load pattern/mask and clear the counter in the same cycle.
    task automatic load(input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] m);
        pat_in  = p;
        mask_in = m;
        pat_ld  = 1'b1;
        cnt_clr = 1'b1;
        cyc();
        pat_ld  = 1'b0;
        cnt_clr = 1'b0;
    endtask

    initial begin
        // Reset state
        clr_n = 1'b0;
        cyc(); cyc();
        chk("rst_y", int'(y), 0);
        chk("rst_hits", int'(hits), 0);
        chk("rst_armed", int'(armed), 0);
        clr_n = 1'b1;

        // Overlap mode, default pattern 1011: stream 1011011
        ovl = 1'b1;
        bit_in(1'b1); chk("ovl_b1_y", int'(y), 0);
        bit_in(1'b0); chk("ovl_b2_y", int'(y), 0);
        bit_in(1'b1); chk("ovl_b3_y", int'(y), 0);
        chk("ovl_b3_armed", int'(armed), 0);
        bit_in(1'b1); chk("ovl_b4_y", int'(y), 1);
        chk("ovl_b4_armed", int'(armed), 1);
        bit_in(1'b0); chk("ovl_b5_y", int'(y), 0);
        bit_in(1'b1); chk("ovl_b6_y", int'(y), 0);
        bit_in(1'b1); chk("ovl_b7_y", int'(y), 1);
        chk("ovl_hits", int'(hits), 2);
        chk("ovl_armed_end", int'(armed), 1);

        // Non-overlap mode, same stream
        load(4'b1011, 4'b1111);
        chk("ld_armed", int'(armed), 0);
        chk("ld_hits", int'(hits), 0);
        ovl = 1'b0;
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        bit_in(1'b1); chk("novl_b4_y", int'(y), 1);
        chk("novl_b4_armed", int'(armed), 0);
        bit_in(1'b0); chk("novl_b5_y", int'(y), 0);
        bit_in(1'b1); chk("novl_b6_y", int'(y), 0);
        bit_in(1'b1); chk("novl_b7_y", int'(y), 0);
        chk("novl_hits", int'(hits), 1);
        chk("novl_armed_end", int'(armed), 0);

        // Enable gaps do not break the match
        load(4'b1011, 4'b1111);
        ovl = 1'b1;
        bit_in(1'b1); bit_in(1'b0);
        e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("gap_y", int'(y), 0);
        end
        bit_in(1'b1); chk("gap_b3_y", int'(y), 0);
        bit_in(1'b1); chk("gap_b4_y", int'(y), 1);
        cyc();        chk("gap_idle_y", int'(y), 0);
        chk("gap_hits", int'(hits), 1);

        // Masked pattern 1001/1001 on all-ones stream, then counter saturation
        load(4'b1001, 4'b1001);
        bit_in(1'b1); chk("msk_b1_y", int'(y), 0);
        bit_in(1'b1); chk("msk_b2_y", int'(y), 0);
        bit_in(1'b1); chk("msk_b3_y", int'(y), 0);
        bit_in(1'b1); chk("msk_b4_y", int'(y), 1);
        bit_in(1'b1); chk("msk_b5_y", int'(y), 1);
        chk("msk_hits", int'(hits), 2);
        bit_in(1'b1); chk("sat_b6_hits", int'(hits), 3);
        bit_in(1'b1); chk("sat_b7_hits", int'(hits), 3);
        bit_in(1'b1); chk("sat_b8_y", int'(y), 1);
        chk("sat_b8_hits", int'(hits), 3);
        cnt_clr = 1'b1;
        bit_in(1'b1);
        cnt_clr = 1'b0;
        chk("clrwin_y", int'(y), 1);
        chk("clrwin_hits", int'(hits), 0);

        // Reset mid-sequence restores the default pattern and empties history
        clr_n = 1'b0; cyc(); clr_n = 1'b1;
        bit_in(1'b1); bit_in(1'b0); bit_in(1'b1);
        clr_n = 1'b0; cyc(); clr_n = 1'b1;
        chk("midrst_armed", int'(armed), 0);
        bit_in(1'b1); chk("midrst_y", int'(y), 0);
        chk("midrst_hits", int'(hits), 0);
        bit_in(1'b0); bit_in(1'b1);
        bit_in(1'b1); chk("fresh_y", int'(y), 1);
        chk("fresh_hits", int'(hits), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Watchdog: never let the run hang.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
